// File: rtl/multicycle_control.sv
// Control FSM sequencing the multicycle MIPS datapath, with memory-ready stalls and traps.
// Define MULTICYCLE_JUMP_EN to decode opcode 000010 as a jump; otherwise it traps.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRED_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [5:0]           OPCODE,
  input  logic                 MEM_READY,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWRITE,
  output logic                 IRWrite,
  output logic                 MemREG,
  output logic                 RegDst,
  output logic                 RegWRITE,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ALUOP,
  output logic [1:0]           PCSrc,
  output logic [3:0]           STATE,
  output logic                 ERROR,
  output logic [RETIRED_W-1:0] RETIRED
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_EXEC_I = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Counter only needs to hold MEM_TIMEOUT-1; the limit cycle itself leaves the state.
  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  state_t               state, stateNext;
  logic [CW-1:0]        waitCnt, waitCntNext;
  logic [RETIRED_W-1:0] retired;
  logic                 isWait, timedOut, retire;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state   <= S_FETCH;
      waitCnt <= '0;
      retired <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (retire)
        retired <= retired + 1'b1;
    end
  end

  always_comb begin
    isWait   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    timedOut = (MEM_TIMEOUT != 0) && isWait && !MEM_READY && (waitCnt == WAIT_LIMIT);

    stateNext = state;
    case (state)
      S_FETCH:  if (MEM_READY) stateNext = S_DECODE;
      S_DECODE: begin
        case (OPCODE)
          OP_RTYPE:                          stateNext = S_EXEC_R;
          OP_LW, OP_SW:                      stateNext = S_MEMADR;
          OP_BEQ:                            stateNext = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: stateNext = S_EXEC_I;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:                              stateNext = S_JUMP;
`endif
          default:                           stateNext = S_TRAP;
        endcase
      end
      S_MEMADR: stateNext = (OPCODE == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MEM_READY) stateNext = S_MEMWB;
      S_MEMWB:  stateNext = S_FETCH;
      S_MEMWR:  if (MEM_READY) stateNext = S_FETCH;
      S_EXEC_R: stateNext = S_RWB;
      S_RWB:    stateNext = S_FETCH;
      S_EXEC_I: stateNext = S_IWB;
      S_IWB:    stateNext = S_FETCH;
      S_BRANCH: stateNext = S_FETCH;
      S_JUMP:   stateNext = S_FETCH;
      S_TRAP:   stateNext = S_TRAP;
      default:  stateNext = S_TRAP;
    endcase
    if (timedOut)
      stateNext = S_TRAP;

    // Any state change restarts the wait count, so each wait state starts from zero.
    if (stateNext != state)
      waitCntNext = '0;
    else if (isWait && !MEM_READY)
      waitCntNext = waitCnt + 1'b1;
    else
      waitCntNext = waitCnt;

    retire = (stateNext == S_FETCH) &&
             (state inside {S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BRANCH, S_JUMP});
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWRITE    = 1'b0;
    IRWrite     = 1'b0;
    MemREG      = 1'b0;
    RegDst      = 1'b0;
    RegWRITE    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOP       = 3'b000;
    PCSrc       = 2'b00;
    ERROR       = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = MEM_READY;
        IRWrite = MEM_READY;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemREG   = 1'b1;
        RegWRITE = 1'b1;
      end
      S_MEMWR: begin
        MemWRITE = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOP   = 3'b010;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWRITE = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (OPCODE)
          OP_ANDI: ALUOP = 3'b100;
          OP_ORI:  ALUOP = 3'b011;
          OP_SLTI: ALUOP = 3'b001;
          default: ALUOP = 3'b000;
        endcase
      end
      S_IWB:    RegWRITE = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOP       = 3'b101;
        PCWriteCond = 1'b1;
        PCSrc       = 2'b01;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = 2'b10;
      end
      S_TRAP:   ERROR = 1'b1;
      default:  ERROR = 1'b1;
    endcase
    // Reset masks every side effect even though the state decode keeps running.
    if (!RST_N) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWRITE    = 1'b0;
      MemWRITE    = 1'b0;
      MemRead     = 1'b0;
    end
  end

  assign STATE   = state;
  assign RETIRED = retired;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences the multicycle MIPS datapath (shared memory, IR, A/B, ALUOut registers).
- Supports R-type, lw, sw, beq, addi, andi, ori and slti. Each instruction takes 3-5 states plus memory wait cycles.
- Drives every datapath mux and write enable.
- Stalls on a memory ready handshake. Traps on an illegal opcode or a memory timeout.

Parameters:
- MEM_TIMEOUT, 15: consecutive MEM_READY-low cycles in a wait state before trapping. 0 disables the timeout.
- RETIRED_W, 16: width of the retired-instruction counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  synchronous, active-low reset.
- OPCODE  input  6  IR[31:26]. Stable from DECODE until the next FETCH completes.
- MEM_READY  input  1  memory completes a read/write this cycle.
- PCWrite  output  1  unconditional PC write.
- PCWriteCond  output  1  PC write if ALU Zero (beq).
- IorD  output  1  0 = PC address, 1 = ALUOut address.
- MemRead  output  1  memory read request.
- MemWRITE  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemREG  output  1  1 = write-back from MDR, 0 = from ALUOut.
- RegDst  output  1  1 = rd, 0 = rt.
- RegWRITE  output  1  register file write.
- ALUSrcA  output  1  0 = PC, 1 = A.
- ALUSrcB  output  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- ALUOP  output  3  000 add, 001 slt, 010 R-type funct, 011 or, 100 and, 101 sub.
- PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- STATE  output  4  current state code.
- ERROR  output  1  trap state reached.
- RETIRED  output  RETIRED_W  instructions completed.

Behaviour:
- Reset:
  - RST_N low at a CLK edge sets state to FETCH (code 0), clears the wait counter and sets RETIRED to 0.
  - While RST_N=0, all write enables and memory requests are forced to 0: PCWrite, PCWriteCond, IRWrite, RegWRITE, MemWRITE, MemRead.
- Signal defaults: any signal not listed for a state is 0.
- Output timing: outputs are decoded combinationally from the state. PCWrite and IRWrite in FETCH are the only outputs that also depend on MEM_READY.

States (code: outputs -> next state):
- FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=000, PCSrc=00, PCWrite=IRWrite=MEM_READY. -> DECODE if MEM_READY, else stay.
- DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOP=000 (branch target into ALUOut). Next state by OPCODE:
  - 000000 -> EXEC_R
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000, 001100, 001101 or 001010 -> EXEC_I
  - any other opcode -> TRAP
- MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOP=000. -> MEMRD for lw, MEMWR for sw.
- MEMRD(3): MemRead=1, IorD=1. -> MEMWB on MEM_READY.
- MEMWB(4): RegDst=0, MemREG=1, RegWRITE=1. -> FETCH.
- MEMWR(5): MemWRITE=1, IorD=1. -> FETCH on MEM_READY.
- EXEC_R(6): ALUSrcA=1, ALUSrcB=00, ALUOP=010. -> RWB.
- RWB(7): RegDst=1, MemREG=0, RegWRITE=1. -> FETCH.
- EXEC_I(8): ALUSrcA=1, ALUSrcB=10. ALUOP by opcode: addi 000, andi 100, ori 011, slti 001. -> IWB.
- IWB(9): RegDst=0, MemREG=0, RegWRITE=1. -> FETCH.
- BRANCH(10): ALUSrcA=1, ALUSrcB=00, ALUOP=101, PCWriteCond=1, PCSrc=01. -> FETCH.
- JUMP(11): see Optional Feature.
- TRAP(15): ERROR=1, all enables 0. Stays in TRAP until reset.

Memory timeout:
- Wait states are FETCH, MEMRD and MEMWR.
- The wait counter clears on entry to a wait state and increments each cycle MEM_READY=0.
- If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT with MEM_READY still 0 -> TRAP.
- MEM_READY=1 on the same cycle the count is reached wins: the transfer completes and there is no trap.

RETIRED counter:
- Increments by 1 on each transition into FETCH from MEMWB, MEMWR, RWB, IWB, BRANCH or JUMP.
- Wraps modulo 2^RETIRED_W.
- Does not change in TRAP.

Latency with MEM_READY tied to 1:
- R-type, I-type, sw: 4 cycles.
- lw: 5 cycles.
- beq: 3 cycles.

Optional Feature:
- Macro: MULTICYCLE_JUMP_EN.
- Defined: OPCODE 000010 in DECODE -> JUMP(11). JUMP outputs PCWrite=1, PCSrc=10, then -> FETCH. Counts as retired; 3 cycles total.
- Undefined: 000010 -> TRAP. State code 11 is unreachable.

Test Plan:
- Reset: RST_N=0 for 2 cycles with MEM_READY=1 -> STATE=0, RETIRED=0, all write enables 0. First cycle after release shows FETCH outputs with PCWrite=IRWrite=1.
- R-type: OPCODE=000000, MEM_READY=1 -> STATE sequence 0,1,6,7,0. RegWRITE=1 and RegDst=1 only in state 7. RETIRED 0 to 1.
- lw with stall: OPCODE=100011, MEM_READY low 3 cycles in MEMRD -> sequence 0,1,2,3,3,3,3,4,0. MemRead=IorD=1 throughout MEMRD. MemREG=1 and RegWRITE=1 in state 4.
- I-type decode: back-to-back ori then slti -> ALUOP=011 then 001 in EXEC_I, ALUSrcB=10, RegDst=0 in IWB. RETIRED increases by 2.
- beq then illegal: OPCODE=000100 -> BRANCH with PCWriteCond=1, PCSrc=01, ALUOP=101. Next OPCODE=111111 -> STATE=15, ERROR=1, held 10 cycles until RST_N=0.
- Timeout: MEM_TIMEOUT=15, MEM_READY=0 in FETCH -> TRAP after the 15th low cycle. Repeat with MEM_READY=1 on the 15th cycle -> DECODE, no trap.
- With MULTICYCLE_JUMP_EN: OPCODE=000010 -> sequence 0,1,11,0 with PCWrite=1, PCSrc=10 in state 11. Without the macro -> TRAP.
